// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, long-press flag and optional auto-repeat.
// Optional auto-repeat strobe is built only when BUTTON_AUTO_REPEAT_EN is defined; otherwise repeat_pulse is tied low.
module button_conditioner #(
  parameter int STABLE_CNT = 4,
  parameter int LONG_CNT   = 100,
  parameter int REPEAT_CNT = 25,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_in,
  output logic pb_debounced,
  output logic long_press,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    LONG         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);

  if (STABLE_CNT < 2 || STABLE_CNT > 255 || LONG_CNT <= STABLE_CNT ||
      LONG_CNT > (2**CNT_W) - 1 || REPEAT_CNT < 2 || REPEAT_CNT > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("button_conditioner: illegal parameter combination");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + ONE;
  endfunction

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;
  logic             pb_debounced_q, pb_debounced_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      hold_q         <= '0;
      long_q         <= 1'b0;
      pb_debounced_q <= 1'b0;
    end else begin
      sync1_q        <= pb_in;
      sync2_q        <= sync1_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hold_q         <= hold_d;
      long_q         <= long_d;
      pb_debounced_q <= pb_debounced_d;
    end
  end

  // hold_cnt keeps counting through a short release so a glitch does not delay the long-press mark.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    long_d  = long_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        hold_d = '0;
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= STABLE_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = ONE;
          hold_d  = sat_inc(hold_q);
        end else if (hold_q >= LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else begin
          hold_d = sat_inc(hold_q);
        end
      end
      LONG: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!long_q) hold_d = sat_inc(hold_q);
        if (sync2_q) begin
          state_d = long_q ? LONG : PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= STABLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          hold_d  = '0;
          long_d  = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hold_d  = '0;
        long_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    pb_debounced_d = (state_d == PRESSED) || (state_d == LONG) || (state_d == RELEASE_WAIT);
  end

  assign pb_debounced = pb_debounced_q;
  assign long_press   = long_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  logic [CNT_W-1:0] rep_q, rep_d;
  logic             repeat_pulse_q, repeat_pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q          <= '0;
      repeat_pulse_q <= 1'b0;
    end else begin
      rep_q          <= rep_d;
      repeat_pulse_q <= repeat_pulse_d;
    end
  end

  // Any entry into LONG (including a return from RELEASE_WAIT) restarts the repeat period.
  always_comb begin
    rep_d          = '0;
    repeat_pulse_d = 1'b0;
    if (state_d == LONG) begin
      if (state_q != LONG) begin
        repeat_pulse_d = 1'b1;
      end else if (rep_q >= REPEAT_LAST) begin
        repeat_pulse_d = 1'b1;
      end else begin
        rep_d = sat_inc(rep_q);
      end
    end
  end

  assign repeat_pulse = repeat_pulse_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters; expected outputs queued per cycle, then compared.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic pb_in;
  logic pb_debounced;
  logic long_press;
  logic repeat_pulse;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic R = 1'b1;
`else
  localparam logic R = 1'b0;
`endif

  int asserts = 0;
  int fails   = 0;
  logic [2:0] exp_q[$];
  string      tag_q[$];

  button_conditioner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_in        (pb_in),
    .pb_debounced (pb_debounced),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic compare_front();
    logic [2:0] o;
    logic [2:0] e;
    string      t;
    o = {pb_debounced, long_press, repeat_pulse};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    asserts++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed{deb,long,rep}=%b expected=%b at %0t", t, o, e, $time);
    end
  endtask

  task automatic expect_now(input logic [2:0] v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
    compare_front();
  endtask

  task automatic step(input logic [2:0] v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic run(input int n, input logic [2:0] v, input string tag);
    for (int i = 0; i < n; i++) step(v, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    pb_in = 1'b0;
    #12;
    expect_now(3'b000, "reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(3, 3'b000, "idle");

    // Long hold: rise at edge 6, long_press at edge 106, repeats every 25, release from LONG.
    pb_in = 1'b1;
    run(5, 3'b000, "press_qualify");
    step(3'b100, "deb_rise_edge6");
    run(99, 3'b100, "pressed_hold");
    step({2'b11, R}, "long_entry");
    for (int k = 0; k < 4; k++) begin
      run(24, 3'b110, "long_no_repeat");
      step({2'b11, R}, "long_repeat");
    end
    pb_in = 1'b0;
    run(5, 3'b110, "long_release_wait");
    step(3'b000, "long_release_fall");
    run(5, 3'b000, "idle_after_long");

    // Three-cycle bounce is rejected.
    pb_in = 1'b1;
    run(3, 3'b000, "bounce_high");
    pb_in = 1'b0;
    run(20, 3'b000, "bounce_reject");

    // Four-cycle press is the shortest accepted one.
    pb_in = 1'b1;
    run(4, 3'b000, "min_press_high");
    pb_in = 1'b0;
    step(3'b000, "min_press_wait");
    step(3'b100, "min_press_rise");
    run(3, 3'b100, "min_press_hold");
    step(3'b000, "min_press_fall");
    run(5, 3'b000, "idle_after_min");

    // Two-cycle low glitch while PRESSED: no drop, long_press still at edge 106.
    pb_in = 1'b1;
    run(5, 3'b000, "glitch_qualify");
    step(3'b100, "glitch_rise");
    run(20, 3'b100, "glitch_pre");
    pb_in = 1'b0;
    run(2, 3'b100, "glitch_low");
    pb_in = 1'b1;
    run(77, 3'b100, "glitch_post");
    step({2'b11, R}, "glitch_long_mark");
    pb_in = 1'b0;
    run(5, 3'b110, "glitch_release_wait");
    step(3'b000, "glitch_release_fall");
    run(3, 3'b000, "idle_after_glitch");

    // Reset during PRESS_WAIT, then requalify with pb_in still high.
    pb_in = 1'b1;
    run(4, 3'b000, "rst_pw_qualify");
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(3'b000, "rst_pw_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(5, 3'b000, "rst_pw_requalify");
    step(3'b100, "rst_pw_rise");

    // Reset during LONG clears every output without a clock edge.
    run(99, 3'b100, "rst_long_hold");
    step({2'b11, R}, "rst_long_entry");
    run(3, 3'b110, "rst_long_in_long");
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(3'b000, "rst_long_async");
    @(posedge clk);
    #1;
    expect_now(3'b000, "rst_long_held");
    rst_n = 1'b1;
    run(5, 3'b000, "rst_long_requalify");
    step(3'b100, "rst_long_rise");
    pb_in = 1'b0;
    run(5, 3'b100, "final_release_wait");
    step(3'b000, "final_release_fall");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter STABLE_CNT, default 4: consecutive agreeing synchronized samples required to accept a level change; legal range 2..255.
REQ-002 Parameter LONG_CNT, default 100: cycles in PRESSED before long press is declared; legal range STABLE_CNT+1..2^CNT_W-1.
REQ-003 Parameter REPEAT_CNT, default 25: auto-repeat period in cycles; legal range 2..2^CNT_W-1.
REQ-004 Parameter CNT_W, default 8: width of every internal counter.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port pb_in, input, 1: raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-008 Port pb_debounced, output, 1: registered clean level, intended as the in_trig of the downstream edge-to-pulse stage.
REQ-009 Port long_press, output, 1: registered level, high while a held press has exceeded LONG_CNT.
REQ-010 Port repeat_pulse, output, 1: registered single-cycle auto-repeat strobe.

Function
REQ-011 pb_in SHALL pass a 2-flop synchronizer (sync1, sync2); only sync2 drives the FSM.
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, LONG, RELEASE_WAIT; all outputs are decoded from registered state/flags, never from pb_in.
REQ-013 IDLE: sync2=1 -> PRESS_WAIT with cnt=1; else stay.
REQ-014 PRESS_WAIT: sync2=0 -> IDLE (bounce rejected, pb_debounced stays 0); sync2=1 and cnt=STABLE_CNT-1 -> PRESSED with hold_cnt=0; else cnt+1.
REQ-015 pb_debounced SHALL be 1 exactly in PRESSED, LONG and RELEASE_WAIT; with pb_in held high from a reset-idle state it rises after STABLE_CNT+2 rising edges.
REQ-016 PRESSED: sync2=0 -> RELEASE_WAIT with cnt=1; hold_cnt=LONG_CNT-1 -> LONG and long_press set; else hold_cnt+1.
REQ-017 LONG: sync2=0 -> RELEASE_WAIT with cnt=1; else stay.
REQ-018 RELEASE_WAIT: sync2=1 -> return to LONG if long_press=1, else PRESSED (hold_cnt retained, not cleared); sync2=0 and cnt=STABLE_CNT-1 -> IDLE, clearing long_press; else cnt+1.
REQ-019 Release latency: pb_debounced falls STABLE_CNT+2 edges after pb_in goes low and stays low.
REQ-020 Counters SHALL saturate, never wrap; hold_cnt frozen while in LONG.
REQ-021 A glitch of duration below STABLE_CNT cycles (after synchronization) SHALL never change pb_debounced.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, sync1=sync2=0, all counters 0, pb_debounced=0, long_press=0, repeat_pulse=0, including mid-press or mid-debounce.
REQ-023 After rst_n release with pb_in already high, the block SHALL treat it as a new press (full STABLE_CNT qualification).

Configuration
REQ-024 Macro BUTTON_AUTO_REPEAT_EN defined: repeat_pulse SHALL pulse one cycle on the edge entering LONG and then every REPEAT_CNT cycles while in LONG; a repeat counter resets on LONG entry and stops outside LONG.
REQ-025 Macro undefined: repeat counter not built; repeat_pulse port still present and constantly 0; all other behaviour identical.

Verification
REQ-026 pb_in 0->1 held, defaults -> pb_debounced=1 after edge 6, long_press=1 after further 100 edges, no earlier change.
REQ-027 pb_in high for 3 cycles then low (bounce), defaults -> pb_debounced never rises, state returns to IDLE.
REQ-028 Held press, then 2-cycle low glitch in PRESSED -> pb_debounced stays 1, hold_cnt resumes, long_press still at original 100-cycle mark +0.
REQ-029 BUTTON_AUTO_REPEAT_EN defined, REPEAT_CNT=25, hold 200 cycles -> repeat_pulse at LONG entry then every 25 cycles, each exactly 1 cycle wide; undefined -> repeat_pulse always 0.
REQ-030 rst_n asserted during PRESS_WAIT and during LONG -> all outputs 0 asynchronously; with pb_in still high after release, pb_debounced rises 6 edges later.
REQ-031 Release from LONG -> pb_debounced and long_press both fall on the same edge, 6 edges after pb_in low.
